// File: rtl/bin_to_bcd_display.sv
// Sequential 8-bit binary to four-digit display-code converter (double-dabble).
// Emits BCD digits with blanked leading zeros and a minus sign next to the leading digit.
module bin_to_bcd_display (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       signed_mode,
  input  logic [7:0] value,
  output logic       busy,
  output logic       done,
  output logic [3:0] dig3,
  output logic [3:0] dig2,
  output logic [3:0] dig1,
  output logic [3:0] dig0
);

  localparam logic [3:0] MINUS_CODE = 4'b1111;
  localparam logic [3:0] BLANK_CODE = 4'b1110;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FORMAT
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  mag_q,   mag_d;
  logic [11:0] bcd_q,   bcd_d;
  logic [2:0]  cnt_q,   cnt_d;
  logic        neg_q,   neg_d;
  logic        busy_q,  busy_d;
  logic        done_q,  done_d;
  logic [3:0]  dig3_q,  dig3_d;
  logic [3:0]  dig2_q,  dig2_d;
  logic [3:0]  dig1_q,  dig1_d;
  logic [3:0]  dig0_q,  dig0_d;

  logic [11:0] bcd_adj;
  logic [3:0]  hun, ten, one;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  assign hun = bcd_q[11:8];
  assign ten = bcd_q[7:4];
  assign one = bcd_q[3:0];
  assign bcd_adj = {add3(hun), add3(ten), add3(one)};

  // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dig3_d  = dig3_q;
    dig2_d  = dig2_q;
    dig1_d  = dig1_q;
    dig0_d  = dig0_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          neg_d   = signed_mode & value[7];
          mag_d   = (signed_mode & value[7]) ? (~value + 8'd1) : value;
          bcd_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        {bcd_d, mag_d} = {bcd_adj[10:0], mag_q, 1'b0};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = FORMAT;
      end

      FORMAT: begin
        dig0_d = one;
        dig1_d = (hun != 4'd0 || ten != 4'd0) ? ten : BLANK_CODE;
        dig2_d = (hun != 4'd0) ? hun : BLANK_CODE;
        dig3_d = BLANK_CODE;
        // The sign takes the first blank position left of the leading digit.
        if (neg_q) begin
          if (hun != 4'd0)      dig3_d = MINUS_CODE;
          else if (ten != 4'd0) dig2_d = MINUS_CODE;
          else                  dig1_d = MINUS_CODE;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mag_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dig3_q  <= BLANK_CODE;
      dig2_q  <= BLANK_CODE;
      dig1_q  <= BLANK_CODE;
      dig0_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dig3_q  <= dig3_d;
      dig2_q  <= dig2_d;
      dig1_q  <= dig1_d;
      dig0_q  <= dig0_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dig3 = dig3_q;
  assign dig2 = dig2_q;
  assign dig1 = dig1_q;
  assign dig0 = dig0_q;

endmodule
